// File: rtl/mult_div_if.sv
// Request/result bundle between the execute stage and the multicycle
// multiply/divide unit.
interface mult_div_if #(
  parameter int WORD_W = 32
);
  logic              start;
  logic [1:0]        md_op;
  logic [WORD_W-1:0] port_a;
  logic [WORD_W-1:0] port_b;
  logic              busy;
  logic              done;
  logic              div_zero;
  logic [WORD_W-1:0] hi;
  logic [WORD_W-1:0] lo;

  modport master (
    output start, md_op, port_a, port_b,
    input  busy, done, div_zero, hi, lo
  );

  modport slave (
    input  start, md_op, port_a, port_b,
    output busy, done, div_zero, hi, lo
  );
endinterface

// File: rtl/mult_div_unit.sv
// Multicycle MULT/MULTU/DIV/DIVU unit: radix-2 shift-add multiply and restoring
// divide on operand magnitudes, followed by a sign-fix cycle into HI/LO.
module mult_div_unit #(
  parameter int WORD_W = 32
) (
  input  logic       clk,
  input  logic       rst,
  mult_div_if.slave  bus
);

  localparam int CNT_W = (WORD_W > 2) ? $clog2(WORD_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_W - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } state_t;

  state_t state, state_next;

  logic [2*WORD_W-1:0] acc;
  logic [WORD_W-1:0]   dvsr;
  logic [CNT_W-1:0]    cnt;
  logic                op_div;
  logic                a_neg;
  logic                b_neg;
  logic                div_zero_q;
  logic [WORD_W-1:0]   hi_q;
  logic [WORD_W-1:0]   lo_q;

  // Request decode: md_op[1] selects divide, md_op[0]=0 selects the signed form.
  logic              accept;
  logic              req_div;
  logic              req_signed;
  logic              req_zero;
  logic [WORD_W-1:0] mag_a;
  logic [WORD_W-1:0] mag_b;

  assign accept     = bus.start && (state == S_IDLE || state == S_DONE);
  assign req_div    = bus.md_op[1];
  assign req_signed = ~bus.md_op[0];
  assign req_zero   = req_div && (bus.port_b == '0);
  assign mag_a      = (req_signed && bus.port_a[WORD_W-1]) ? -bus.port_a : bus.port_a;
  assign mag_b      = (req_signed && bus.port_b[WORD_W-1]) ? -bus.port_b : bus.port_b;

  // NOTE: the state register uses <= so every flop samples pre-edge values;
  // blocking here would let later always_ff blocks see the new state early.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // NOTE: state_next gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE, S_DONE: begin
        if (accept)               state_next = req_zero ? S_DONE : S_CALC;
        else if (state == S_DONE) state_next = S_IDLE;
      end
      S_CALC:  if (cnt == CNT_LAST) state_next = S_FIX;
      S_FIX:   state_next = S_DONE;
      default: state_next = S_IDLE;
    endcase
  end

  // Iteration step. Multiply keeps {partial_hi, multiplier} in acc and shifts right;
  // divide keeps {remainder, dividend/quotient} and shifts left.
  logic [WORD_W:0]     mul_sum;
  logic [2*WORD_W-1:0] mul_step;
  logic [2*WORD_W:0]   div_shift;
  logic [WORD_W:0]     div_diff;
  logic [2*WORD_W-1:0] div_step;
  logic [2*WORD_W-1:0] prod_fix;
  logic [WORD_W-1:0]   quot_fix;
  logic [WORD_W-1:0]   rem_fix;

  always_comb begin
    mul_sum   = {1'b0, acc[2*WORD_W-1:WORD_W]}
              + {1'b0, (acc[0] ? dvsr : {WORD_W{1'b0}})};
    mul_step  = {mul_sum, acc[WORD_W-1:1]};
    div_shift = {acc, 1'b0};
    div_diff  = div_shift[2*WORD_W:WORD_W] - {1'b0, dvsr};
    div_step  = div_diff[WORD_W] ? div_shift[2*WORD_W-1:0]
                                 : {div_diff[WORD_W-1:0], div_shift[WORD_W-1:1], 1'b1};
    prod_fix  = (a_neg ^ b_neg) ? -acc : acc;
    quot_fix  = (a_neg ^ b_neg) ? -acc[WORD_W-1:0] : acc[WORD_W-1:0];
    rem_fix   = a_neg ? -acc[2*WORD_W-1:WORD_W] : acc[2*WORD_W-1:WORD_W];
  end

  // NOTE: the datapath has no memory arrays, so every register is cleared on
  // reset; that keeps hi/lo at zero and drops any in-flight operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc        <= '0;
      dvsr       <= '0;
      cnt        <= '0;
      op_div     <= 1'b0;
      a_neg      <= 1'b0;
      b_neg      <= 1'b0;
      div_zero_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (accept) begin
            op_div     <= req_div;
            a_neg      <= req_signed && bus.port_a[WORD_W-1];
            b_neg      <= req_signed && bus.port_b[WORD_W-1];
            dvsr       <= mag_b;
            acc        <= {{WORD_W{1'b0}}, mag_a};
            cnt        <= '0;
            div_zero_q <= req_zero;
            if (req_zero) begin
              hi_q <= bus.port_a;
              lo_q <= '1;
            end
          end
        end
        S_CALC: begin
          cnt <= cnt + 1'b1;
          acc <= op_div ? div_step : mul_step;
        end
        S_FIX: begin
          if (op_div) begin
            hi_q <= rem_fix;
            lo_q <= quot_fix;
          end else begin
            hi_q <= prod_fix[2*WORD_W-1:WORD_W];
            lo_q <= prod_fix[WORD_W-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy     = (state == S_CALC) || (state == S_FIX);
  assign bus.done     = (state == S_DONE);
  assign bus.div_zero = div_zero_q;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;

endmodule
